// File: rtl/monolith_bars_inv_if.sv
// Valid/ready bus carrying a full Monolith state into and out of the inverse Bars block.
interface monolith_bars_inv_if #(
  parameter int unsigned WORD_WIDTH = 31,
  parameter int unsigned STATE_SIZE = 16
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out;

  modport master (output in_valid, state_in, out_ready,
                  input  in_ready, out_valid, state_out);
  modport slave  (input  in_valid, state_in, out_ready,
                  output in_ready, out_valid, state_out);
endinterface

// File: rtl/monolith_bars_inv_seq.sv
// Iterative inverse Monolith Bars layer over Mersenne-31 words, LANES words per cycle,
// using inverse S-box tables built at elaboration from the forward chi-style S-box.
module monolith_bars_inv_seq #(
  parameter int unsigned WORD_WIDTH   = 31,
  parameter int unsigned STATE_SIZE   = 16,
  parameter int unsigned BAR_OP_COUNT = 8,
  parameter int unsigned LANES        = 1
) (
  input logic               clk,
  input logic               reset,
  monolith_bars_inv_if.slave bus
);

  localparam int unsigned N     = (LANES == 0) ? 0 : BAR_OP_COUNT / LANES;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((N == 0) ? 0 : N - 1);

  if (WORD_WIDTH != 31) begin : g_bad_width
    $error("monolith_bars_inv_seq: WORD_WIDTH must be 31");
  end
  if (LANES == 0 || (BAR_OP_COUNT % LANES) != 0) begin : g_bad_lanes
    $error("monolith_bars_inv_seq: LANES must divide BAR_OP_COUNT");
  end
  if (BAR_OP_COUNT > STATE_SIZE) begin : g_bad_count
    $error("monolith_bars_inv_seq: BAR_OP_COUNT exceeds STATE_SIZE");
  end

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] r1, r2, r3, t;
    r1 = {x[6:0], x[7]};
    r2 = {x[5:0], x[7:6]};
    r3 = {x[4:0], x[7:5]};
    t  = x ^ (~r1 & r2 & r3);
    return {t[6:0], t[7]};
  endfunction

  function automatic logic [6:0] sbox7(input logic [6:0] x);
    logic [6:0] r1, r2, r3, t;
    r1 = {x[5:0], x[6]};
    r2 = {x[4:0], x[6:5]};
    r3 = {x[3:0], x[6:4]};
    t  = x ^ (~r1 & r2 & r3);
    return {t[5:0], t[6]};
  endfunction

  // Invert by scattering: entry S(x) holds x, the S-box being a permutation.
  function automatic logic [255:0][7:0] build_inv8();
    logic [255:0][7:0] t;
    t = '0;
    for (int x = 0; x < 256; x++) t[sbox8(8'(x))] = 8'(x);
    return t;
  endfunction

  function automatic logic [127:0][6:0] build_inv7();
    logic [127:0][6:0] t;
    t = '0;
    for (int x = 0; x < 128; x++) t[sbox7(7'(x))] = 7'(x);
    return t;
  endfunction

  localparam logic [255:0][7:0] SINV8 = build_inv8();
  localparam logic [127:0][6:0] SINV7 = build_inv7();

  function automatic logic [30:0] inv_word(input logic [30:0] w);
    return {SINV7[w[30:24]], SINV8[w[23:16]], SINV8[w[15:8]], SINV8[w[7:0]]};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] work_q, work_d;
  logic                                  in_ready_q, out_valid_q;
  logic [IDX_W-1:0]                      idx;

  // Next-state and in-place datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    idx     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.state_in;
          cnt_d   = '0;
          state_d = (N == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < int'(LANES); l++) begin
          idx         = IDX_W'(int'(cnt_q) * int'(LANES) + l);
          work_d[idx] = inv_word(work_q[idx]);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = work_q;

endmodule

// File: tb/tb_monolith_bars_inv_seq.sv
// Directed bench for monolith_bars_inv_seq: reset, known vectors, backpressure, round trip.
module tb_monolith_bars_inv_seq;

  typedef logic [15:0][30:0] st_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  monolith_bars_inv_if #(.WORD_WIDTH(31), .STATE_SIZE(16)) b0 ();
  monolith_bars_inv_if #(.WORD_WIDTH(31), .STATE_SIZE(16)) b4 ();

  assign b4.in_valid  = b0.in_valid;
  assign b4.state_in  = b0.state_in;
  assign b4.out_ready = b0.out_ready;

  monolith_bars_inv_seq #(.WORD_WIDTH(31), .STATE_SIZE(16), .BAR_OP_COUNT(8), .LANES(1)) dut (
    .clk(clk), .reset(reset), .bus(b0));

  monolith_bars_inv_seq #(.WORD_WIDTH(31), .STATE_SIZE(16), .BAR_OP_COUNT(8), .LANES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));

  function automatic logic [7:0] s8(input logic [7:0] x);
    logic [7:0] t;
    t = x ^ (~{x[6:0], x[7]} & {x[5:0], x[7:6]} & {x[4:0], x[7:5]});
    return {t[6:0], t[7]};
  endfunction

  function automatic logic [6:0] s7(input logic [6:0] x);
    logic [6:0] t;
    t = x ^ (~{x[5:0], x[6]} & {x[4:0], x[6:5]} & {x[3:0], x[6:4]});
    return {t[5:0], t[6]};
  endfunction

  function automatic logic [30:0] fwd_word(input logic [30:0] w);
    return {s7(w[30:24]), s8(w[23:16]), s8(w[15:8]), s8(w[7:0])};
  endfunction

  function automatic st_t fill(input logic [30:0] lo, input logic [30:0] hi);
    st_t s;
    for (int w = 0; w < 16; w++) s[w] = (w < 8) ? lo : hi;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input st_t s);
    b0.state_in = s;
    b0.in_valid = 1'b1;
    step();
    b0.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (b0.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop();
    b0.out_ready = 1'b1;
    step();
    b0.out_ready = 1'b0;
  endtask

  st_t kv_in, kv_out, x, y, res, sb;
  int  lat, lat0, lat4, outs;
  logic acc, got;

  initial begin
    reset        = 1'b0;
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b0;
    b0.state_in  = '0;
    kv_in  = fill(31'h02020202, 31'h12345678);
    kv_out = fill(31'h01010101, 31'h12345678);
    repeat (3) step();
    chk("reset_in_ready", 512'(b0.in_ready), 512'(1'b1));
    chk("reset_out_valid", 512'(b0.out_valid), 512'(1'b0));
    chk("reset_state", 512'(b0.state_out), 512'(0));
    reset = 1'b1;
    step();

    // Known vector on both lane widths, latency measured from the accept edge.
    send(kv_in);
    chk("run_in_ready", 512'(b0.in_ready), 512'(1'b0));
    lat0 = 0;
    lat4 = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (lat0 == 0 && b0.out_valid) lat0 = i;
      if (lat4 == 0 && b4.out_valid) lat4 = i;
      if (lat0 != 0 && lat4 != 0) break;
    end
    chk("latency_lanes1", 512'(lat0), 512'(8));
    chk("latency_lanes4", 512'(lat4), 512'(2));
    chk("kv_result", 512'(b0.state_out), 512'(kv_out));
    chk("kv_result_lanes4", 512'(b4.state_out), 512'(kv_out));
    chk("done_in_ready", 512'(b0.in_ready), 512'(1'b0));
    pop();
    chk("pop_out_valid", 512'(b0.out_valid), 512'(1'b0));
    chk("pop_in_ready", 512'(b0.in_ready), 512'(1'b1));

    // Fixed points: all ones and all zeros.
    send(fill(31'h7FFFFFFF, 31'h7FFFFFFF));
    wait_done(lat);
    chk("fixed_ones", 512'(b0.state_out), 512'(fill(31'h7FFFFFFF, 31'h7FFFFFFF)));
    pop();
    send(fill(31'h0, 31'h0));
    wait_done(lat);
    chk("fixed_zero_lat", 512'(lat), 512'(8));
    chk("fixed_zero", 512'(b0.state_out), 512'(0));
    pop();

    // Backpressure: held output with a pending input, taken one edge after release.
    send(kv_in);
    wait_done(lat);
    sb = fill(31'h02020202, 31'h02020202);
    b0.state_in = sb;
    b0.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_state", 512'(b0.state_out), 512'(kv_out));
      chk("bp_in_ready", 512'(b0.in_ready), 512'(1'b0));
      chk("bp_out_valid", 512'(b0.out_valid), 512'(1'b1));
    end
    b0.out_ready = 1'b1;
    step();
    b0.out_ready = 1'b0;
    chk("bp_release_valid", 512'(b0.out_valid), 512'(1'b0));
    chk("bp_release_ready", 512'(b0.in_ready), 512'(1'b1));
    chk("bp_release_state", 512'(b0.state_out), 512'(kv_out));
    step();
    b0.in_valid = 1'b0;
    chk("bp_accept_ready", 512'(b0.in_ready), 512'(1'b0));
    chk("bp_accept_state", 512'(b0.state_out), 512'(sb));
    wait_done(lat);
    chk("bp_second_lat", 512'(lat), 512'(8));
    chk("bp_second_result", 512'(b0.state_out), 512'(fill(31'h01010101, 31'h02020202)));
    pop();

    // Asynchronous reset in the middle of a run.
    send(kv_in);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("midrun_in_ready", 512'(b0.in_ready), 512'(1'b1));
    chk("midrun_out_valid", 512'(b0.out_valid), 512'(1'b0));
    chk("midrun_state", 512'(b0.state_out), 512'(0));
    step();
    reset = 1'b1;
    step();
    send(kv_in);
    wait_done(lat);
    chk("post_reset_lat", 512'(lat), 512'(8));
    chk("post_reset_result", 512'(b0.state_out), 512'(kv_out));
    pop();

    // Round trip through the forward Bars model with random stalls.
    outs = 0;
    for (int n = 0; n < 200; n++) begin
      for (int w = 0; w < 16; w++) begin
        x[w] = 31'($urandom);
        y[w] = (w < 8) ? fwd_word(x[w]) : x[w];
      end
      repeat ($urandom_range(0, 2)) step();
      b0.state_in = y;
      b0.in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) begin
        acc = b0.in_ready;
        step();
      end
      b0.in_valid = 1'b0;
      got = 1'b0;
      res = '0;
      for (int i = 0; i < 80 && !got; i++) begin
        b0.out_ready = 1'($urandom_range(0, 1));
        got = b0.out_valid & b0.out_ready;
        if (got) res = b0.state_out;
        step();
      end
      b0.out_ready = 1'b0;
      if (acc && got) outs++;
      chk("roundtrip", 512'(res), 512'(x));
    end
    chk("roundtrip_count", 512'(outs), 512'(200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
